// File: rtl/blob_pkg.sv
// Purpose : shared types and helpers for the mask blob tracker and the filter chain.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package blob_pkg;

    // Default frame geometry shared with the colour-dominance filter chain.
    localparam int DEF_IMG_W = 640;
    localparam int DEF_IMG_H = 480;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ACCUM = 3'd1,
        S_DIV_X = 3'd2,
        S_DIV_Y = 3'd3,
        S_DONE  = 3'd4
    } blob_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Purpose : unsigned restoring divider, one quotient bit per cycle.
// Latency : done pulses W cycles after start; quotient valid while done is high.
// Backpressure: none; a new start restarts the divider and discards any division in flight.
// Ports   : clk, rst (async, active-high), start, dividend[W], divisor[W] -> quotient[W], done.
module seq_divider #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic         done
);
    localparam int NW = $clog2(W + 1);

    logic [W-1:0]  rem_r, dvs_r;
    logic [W-1:0]  rem_src, q_src, dvs_src, rem_nx, q_nx;
    logic [W:0]    shifted, diff;
    logic [NW-1:0] steps_left;

    // The start cycle already performs the first step on the raw inputs, so
    // W steps complete in W edges and done lands exactly W cycles after start.
    always_comb begin
        rem_src = start ? '0       : rem_r;
        q_src   = start ? dividend : quotient;
        dvs_src = start ? divisor  : dvs_r;
        shifted = {rem_src, q_src[W-1]};
        // rem < divisor always holds, so bit W of diff is a clean borrow flag.
        diff    = shifted - {1'b0, dvs_src};
        rem_nx  = diff[W] ? shifted[W-1:0] : diff[W-1:0];
        q_nx    = {q_src[W-2:0], ~diff[W]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_r      <= '0;
            dvs_r      <= '0;
            quotient   <= '0;
            steps_left <= '0;
            done       <= 1'b0;
        end else if (start) begin
            rem_r      <= rem_nx;
            quotient   <= q_nx;
            dvs_r      <= divisor;
            steps_left <= NW'(W - 1);
            done       <= (W == 1);
        end else if (steps_left != '0) begin
            rem_r      <= rem_nx;
            quotient   <= q_nx;
            steps_left <= steps_left - 1'b1;
            done       <= (steps_left == NW'(1));
        end else begin
            done       <= 1'b0;
        end
    end

endmodule

// File: rtl/mask_blob_tracker.sv
// Purpose : per-frame hit count, bounding box and centroid of a 4-bit mask stream.
// Latency : result_valid 2*SUM_W+1 cycles after the last pixel (1 cycle for an empty frame).
// Backpressure: none; in_ready is a pure valid, pixels outside ACCUM/frame_start are dropped.
// Ports   : clk, rst (async, active-high), frame_start, pixel_in[4], in_ready ->
//           result_valid, detected, count[CW], min_x/max_x[XW], min_y/max_y[YW],
//           cent_x[XW], cent_y[YW], busy.
module mask_blob_tracker
    import blob_pkg::*;
#(
    parameter  int IMG_W       = DEF_IMG_W,
    parameter  int IMG_H       = DEF_IMG_H,
    parameter  int MASK_THRESH = 8,
    parameter  int MIN_PIXELS  = 64,
    localparam int XW          = $clog2(IMG_W),
    localparam int YW          = $clog2(IMG_H),
    localparam int CW          = $clog2(IMG_W * IMG_H + 1),
    localparam int SUM_W       = max_int(XW, YW) + CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_start,
    input  logic [3:0]    pixel_in,
    input  logic          in_ready,
    output logic          result_valid,
    output logic          detected,
    output logic [CW-1:0] count,
    output logic [XW-1:0] min_x,
    output logic [XW-1:0] max_x,
    output logic [YW-1:0] min_y,
    output logic [YW-1:0] max_y,
    output logic [XW-1:0] cent_x,
    output logic [YW-1:0] cent_y,
    output logic          busy
);
    localparam logic [3:0]    THRESH  = 4'(MASK_THRESH);
    localparam logic [CW-1:0] MIN_CNT = CW'(MIN_PIXELS);
    localparam logic [XW-1:0] X_LAST  = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(IMG_H - 1);

    blob_state_t      state, state_n;
    logic [XW-1:0]    x_cnt, cur_x, x_n, minx_r, maxx_r, minx_b, maxx_b, minx_n, maxx_n, cent_x_r;
    logic [YW-1:0]    y_cnt, cur_y, y_n, miny_r, maxy_r, miny_b, maxy_b, miny_n, maxy_n;
    logic [CW-1:0]    acc_cnt, cnt_b, cnt_n;
    logic [SUM_W-1:0] sum_x_r, sum_y_r, sx_b, sy_b, sx_n, sy_n;
    logic             accept, hit, last_beat, start_x, start_y;
    logic [SUM_W-1:0] div_dividend, div_divisor, div_quot;
    logic             div_done;
    logic             unused_quot;

    // frame_start clears everything in the same cycle, so the coincident pixel
    // is accumulated as (0,0) against an empty frame ("_b" = base values).
    always_comb begin
        cur_x  = frame_start ? '0 : x_cnt;
        cur_y  = frame_start ? '0 : y_cnt;
        cnt_b  = frame_start ? '0 : acc_cnt;
        sx_b   = frame_start ? '0 : sum_x_r;
        sy_b   = frame_start ? '0 : sum_y_r;
        minx_b = frame_start ? '0 : minx_r;
        maxx_b = frame_start ? '0 : maxx_r;
        miny_b = frame_start ? '0 : miny_r;
        maxy_b = frame_start ? '0 : maxy_r;

        accept = in_ready && (frame_start || state == S_ACCUM);
        hit    = accept && (pixel_in >= THRESH);

        cnt_n  = cnt_b;
        sx_n   = sx_b;
        sy_n   = sy_b;
        minx_n = minx_b;
        maxx_n = maxx_b;
        miny_n = miny_b;
        maxy_n = maxy_b;
        if (hit) begin
            cnt_n = cnt_b + 1'b1;
            sx_n  = sx_b + SUM_W'(cur_x);
            sy_n  = sy_b + SUM_W'(cur_y);
            if (cnt_b == '0) begin
                minx_n = cur_x;
                maxx_n = cur_x;
                miny_n = cur_y;
                maxy_n = cur_y;
            end else begin
                if (cur_x < minx_b) minx_n = cur_x;
                if (cur_x > maxx_b) maxx_n = cur_x;
                if (cur_y < miny_b) miny_n = cur_y;
                if (cur_y > maxy_b) maxy_n = cur_y;
            end
        end

        x_n = cur_x;
        y_n = cur_y;
        if (accept) begin
            if (cur_x == X_LAST) begin
                x_n = '0;
                y_n = (cur_y == Y_LAST) ? '0 : cur_y + 1'b1;
            end else begin
                x_n = cur_x + 1'b1;
            end
        end

        last_beat = accept && (cur_x == X_LAST) && (cur_y == Y_LAST);

        // x division is launched from the final sums in the last-beat cycle and
        // y is launched the cycle x finishes; this keeps each divide state at
        // exactly SUM_W cycles.
        start_x = last_beat && (cnt_n != '0);
        start_y = !frame_start && (state == S_DIV_X) && div_done;

        div_dividend = start_x ? sx_n : sum_y_r;
        div_divisor  = SUM_W'(cnt_n);

        state_n = state;
        if (last_beat) begin
            state_n = (cnt_n == '0) ? S_DONE : S_DIV_X;
        end else if (frame_start) begin
            state_n = S_ACCUM;
        end else begin
            case (state)
                S_DIV_X: if (div_done) state_n = S_DIV_Y;
                S_DIV_Y: if (div_done) state_n = S_DONE;
                S_DONE:  state_n = S_IDLE;
                default: state_n = state;
            endcase
        end
    end

    seq_divider #(.W(SUM_W)) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (start_x || start_y),
        .dividend (div_dividend),
        .divisor  (div_divisor),
        .quotient (div_quot),
        .done     (div_done)
    );

    // Quotients are always below IMG_W/IMG_H, so only the low bits matter.
    assign unused_quot = ^div_quot;
    assign busy        = (state == S_DIV_X) || (state == S_DIV_Y);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            x_cnt        <= '0;
            y_cnt        <= '0;
            acc_cnt      <= '0;
            sum_x_r      <= '0;
            sum_y_r      <= '0;
            minx_r       <= '0;
            maxx_r       <= '0;
            miny_r       <= '0;
            maxy_r       <= '0;
            cent_x_r     <= '0;
            result_valid <= 1'b0;
            detected     <= 1'b0;
            count        <= '0;
            min_x        <= '0;
            max_x        <= '0;
            min_y        <= '0;
            max_y        <= '0;
            cent_x       <= '0;
            cent_y       <= '0;
        end else begin
            state <= state_n;
            if (frame_start || state == S_ACCUM) begin
                x_cnt   <= x_n;
                y_cnt   <= y_n;
                acc_cnt <= cnt_n;
                sum_x_r <= sx_n;
                sum_y_r <= sy_n;
                minx_r  <= minx_n;
                maxx_r  <= maxx_n;
                miny_r  <= miny_n;
                maxy_r  <= maxy_n;
            end
            if (state == S_DIV_X && div_done) cent_x_r <= div_quot[XW-1:0];

            // Results are loaded on the edge entering DONE so they are valid
            // during the result_valid cycle; otherwise they hold.
            result_valid <= 1'b0;
            if (last_beat && cnt_n == '0) begin
                result_valid <= 1'b1;
                detected     <= 1'b0;
                count        <= '0;
                min_x        <= '0;
                max_x        <= '0;
                min_y        <= '0;
                max_y        <= '0;
                cent_x       <= '0;
                cent_y       <= '0;
            end else if (!frame_start && state == S_DIV_Y && div_done) begin
                result_valid <= 1'b1;
                detected     <= (acc_cnt != '0) && (acc_cnt >= MIN_CNT);
                count        <= acc_cnt;
                min_x        <= minx_r;
                max_x        <= maxx_r;
                min_y        <= miny_r;
                max_y        <= maxy_r;
                cent_x       <= cent_x_r;
                cent_y       <= div_quot[YW-1:0];
            end
        end
    end

endmodule
